// File: rtl/uart_pkg.sv
// Shared types and default parameters for the uart frame transmitter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int DEF_CLKS_PER_BIT = 1;
    localparam int DEF_DATA_W       = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: bit_end strobes on the last clock of each serial bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart.sv
// Free-running serial framer: start bit, DATA_W data bits LSB first, stop bit.
// state | meaning
// IDLE  | one cycle, line high, frame inputs latched
// START | latched start level on the line
// DATA  | shift_reg[0] on the line, one bit per bit period
// STOP  | latched stop level on the line
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] data,
    output logic              out,
    output logic              done
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shifted;
    logic              start_q, stop_q;
    logic [BW-1:0]     bit_cnt;
    logic              bit_end, last_bit;
    logic              out_next, done_next;

    assign last_bit = (bit_cnt == LAST_BIT);
    assign shifted  = shift_reg >> 1;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_next != state),
        .bit_end (bit_end)
    );

    // out/done are computed for the upcoming state so the flops present them in step with it
    always_comb begin
        state_next = state;
        out_next   = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE:    state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_bit) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (state_next)
            IDLE: begin
                out_next  = 1'b1;
                done_next = (state == STOP);
            end
            START:   out_next = (state == IDLE) ? start : start_q;
            DATA:    out_next = (state == DATA && bit_end) ? shifted[0] : shift_reg[0];
            STOP:    out_next = stop_q;
            default: out_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out       <= 1'b1;
            done      <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_next;
            out   <= out_next;
            done  <= done_next;
            if (state == IDLE) begin
                start_q   <= start;
                stop_q    <= stop;
                shift_reg <= data;
                bit_cnt   <= '0;
            end else if (state == DATA && bit_end) begin
                shift_reg <= shifted;
                bit_cnt   <= last_bit ? '0 : bit_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart at CLKS_PER_BIT = 1 and 4 sharing one set of inputs.
module tb_uart;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b1;
    logic [7:0] data = 8'h00;
    logic       out1, done1, out4, done4;

    always #5 clk = ~clk;

    uart #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .data(data),
        .out(out1), .done(done1)
    );
    uart #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .data(data),
        .out(out4), .done(done4)
    );

    typedef struct packed {
        logic o;
        logic d;
    } exp_t;
    typedef exp_t eq_t[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    eq_t  q1, q4;
    bit   first1 = 1'b1, first4 = 1'b1;
    int   last1 = -1, last4 = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Whole frame as the line should look cycle by cycle: idle high, then each of
    // start, data[0..7], stop held for cpb cycles. done accompanies the idle cycle
    // whenever a frame has just finished.
    function automatic eq_t frame(input int cpb, input bit dn, input logic s,
                                  input logic [7:0] d, input logic p);
        eq_t         r;
        logic [9:0]  bits;
        exp_t        e;
        bits = {p, d, s};
        e.o = 1'b1; e.d = dn;
        r.push_back(e);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < cpb; k++) begin
                e.o = bits[i]; e.d = 1'b0;
                r.push_back(e);
            end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            check("rst_out1", {31'b0, out1}, 1);
            check("rst_done1", {31'b0, done1}, 0);
            check("rst_out4", {31'b0, out4}, 1);
            check("rst_done4", {31'b0, done4}, 0);
            q1.delete(); q4.delete();
            first1 = 1'b1; first4 = 1'b1;
            last1 = -1; last4 = -1;
        end else begin
            // inputs visible now are the ones each DUT latches at the end of its idle cycle
            if (q1.size() == 0) begin
                q1 = frame(1, !first1, start, data, stop);
                first1 = 1'b0;
            end
            if (q4.size() == 0) begin
                q4 = frame(4, !first4, start, data, stop);
                first4 = 1'b0;
            end
            e = q1.pop_front();
            check("out1", {31'b0, out1}, {31'b0, e.o});
            check("done1", {31'b0, done1}, {31'b0, e.d});
            e = q4.pop_front();
            check("out4", {31'b0, out4}, {31'b0, e.o});
            check("done4", {31'b0, done4}, {31'b0, e.d});
            if (done1 === 1'b1) begin
                if (last1 >= 0) check("period1", cyc - last1, 11);
                last1 = cyc;
            end
            if (done4 === 1'b1) begin
                if (last4 >= 0) check("period4", cyc - last4, 41);
                last4 = cyc;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rand_inputs();
        start = 1'($urandom_range(0, 1));
        stop  = 1'($urandom_range(0, 1));
        data  = 8'($urandom);
    endtask

    initial begin
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            rand_inputs();
        end

        start = 1'b0; stop = 1'b1; data = 8'h5D;
        step(1);
        rst = 1'b1;
        step(45);

        data = 8'hA5;
        step(130);

        // inputs change every cycle, so most changes land mid-frame
        for (int i = 0; i < 700; i++) begin
            rand_inputs();
            step(1);
        end

        start = 1'b1; stop = 1'b0; data = 8'hFF;
        step(90);

        // align both DUTs, then abort while dut1 is in DATA and dut4 in START, line low
        start = 1'b0; stop = 1'b1; data = 8'h00;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        #1;
        check("async_out1", {31'b0, out1}, 1);
        check("async_out4", {31'b0, out4}, 1);
        check("async_done1", {31'b0, done1}, 0);
        check("async_done4", {31'b0, done4}, 0);
        step(3);
        rst = 1'b1;
        data = 8'h3C;
        step(50);
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
